// File: rtl/wb_bus_master_arbiter_pkg.sv
// Shared types and constants for the Wishbone multi-master arbiter slice.
package wb_bus_master_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2
  } state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  // Supports up to 32 requesters; callers zero-extend their one-hot vector.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) begin
        idx = idx | 5'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_bus_master_arbiter_arb_rr.sv
// Combinational round-robin arbiter: the first requester after the current
// holder wins; with no request the current grant is returned unchanged.
module wb_interconnect_arb_rr
  import wb_bus_master_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] gnt_i,
  output logic [N-1:0] nxt_gnt_o
);

  // Scan from holder+1 upward with wrap; the holder itself is searched last.
  always_comb begin : rr_scan
    logic [31:0] gnt_ext;
    int          cur;
    int          idx;
    logic        found;
    gnt_ext            = 32'd0;
    gnt_ext[N-1:0]     = gnt_i;
    cur                = int'(onehot_to_idx(gnt_ext));
    idx                = 0;
    found              = 1'b0;
    nxt_gnt_o          = gnt_i;
    for (int i = 1; i <= N; i++) begin
      idx = (cur + i) % N;
      if (!found && req_i[idx]) begin
        nxt_gnt_o      = '0;
        nxt_gnt_o[idx] = 1'b1;
        found          = 1'b1;
      end else begin
        found          = found;
      end
    end
  end

endmodule

// File: rtl/wb_bus_master_arbiter.sv
// Shares one Wishbone B3 bus between N masters with a registered round-robin
// grant held for the whole cycle, termination routing and a stall watchdog.
module wb_bus_master_arbiter
  import wb_bus_master_arbiter_pkg::*;
#(
  parameter int N          = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256,
  parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N-1:0]            m_cyc_i,
  input  logic [N-1:0]            m_stb_i,
  input  logic [N-1:0]            m_we_i,
  input  logic [N*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [N*DATA_WIDTH-1:0] m_dat_i,
  input  logic [N*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [N*3-1:0]          m_cti_i,
  input  logic [N*2-1:0]          m_bte_i,
  output logic [N-1:0]            m_ack_o,
  output logic [N-1:0]            m_err_o,
  output logic [N-1:0]            m_rty_o,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [SEL_WIDTH-1:0]    s_sel_o,
  output logic [2:0]              s_cti_o,
  output logic [1:0]              s_bte_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [N-1:0]            gnt_o
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LIMIT = WDW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d, nxt_gnt_s;
  logic [WDW-1:0] wd_q, wd_d;
  logic [31:0]    gnt_ext_s;
  int             g_s;
  logic           term_s;

  wb_interconnect_arb_rr #(.N(N)) u_arb (
    .req_i     (m_cyc_i),
    .gnt_i     (gnt_q),
    .nxt_gnt_o (nxt_gnt_s)
  );

  assign term_s  = s_ack_i | s_err_i | s_rty_i;
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;

  // Bus mux and termination routing, both steered by the registered grant.
  always_comb begin
    gnt_ext_s          = 32'd0;
    gnt_ext_s[N-1:0]   = gnt_q;
    g_s                = int'(onehot_to_idx(gnt_ext_s));
    s_we_o             = m_we_i[g_s];
    s_adr_o            = m_adr_i[g_s*ADDR_WIDTH +: ADDR_WIDTH];
    s_dat_o            = m_dat_i[g_s*DATA_WIDTH +: DATA_WIDTH];
    s_sel_o            = m_sel_i[g_s*SEL_WIDTH +: SEL_WIDTH];
    s_cti_o            = m_cti_i[g_s*3 +: 3];
    s_bte_o            = m_bte_i[g_s*2 +: 2];
    s_cyc_o            = 1'b0;
    s_stb_o            = 1'b0;
    m_ack_o            = '0;
    m_err_o            = '0;
    m_rty_o            = '0;
    case (state_q)
      OWN: begin
        s_cyc_o        = m_cyc_i[g_s];
        s_stb_o        = m_stb_i[g_s];
        m_ack_o        = gnt_q & {N{s_ack_i}};
        m_err_o        = gnt_q & {N{s_err_i}};
        m_rty_o        = gnt_q & {N{s_rty_i}};
      end
      ABORT: begin
        m_err_o        = gnt_q;
      end
      default: begin
        s_cyc_o        = 1'b0;
      end
    endcase
  end

  // Ownership FSM and stall watchdog next-state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          gnt_d   = nxt_gnt_s;
          state_d = OWN;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!m_cyc_i[g_s]) begin
          state_d = IDLE;
        end else if ((TIMEOUT > 0) && s_stb_o && !term_s && (wd_q == WD_LIMIT)) begin
          state_d = ABORT;
        end else begin
          state_d = OWN;
        end
      end
      ABORT: begin
        state_d = m_cyc_i[g_s] ? OWN : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if ((TIMEOUT == 0) || (state_d != state_q) || term_s || !s_stb_o) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  // State, grant and watchdog registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= N'(1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_wb_bus_master_arbiter.sv
// Directed bench for wb_bus_master_arbiter with a per-cycle expectation queue.
module tb_wb_bus_master_arbiter;
  import wb_bus_master_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*SW-1:0] m_sel_i;
  logic [N*3-1:0]  m_cti_i;
  logic [N*2-1:0]  m_bte_i;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [DW-1:0]   m_dat_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic            s_ack_i, s_err_i, s_rty_i;
  logic [DW-1:0]   s_dat_i;
  logic [N-1:0]    gnt_o;

  wb_bus_master_arbiter #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
    .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic       cyc;
    logic [3:0] ack;
    logic [3:0] err;
    logic [3:0] rty;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push the expected per-cycle outputs, then pop and compare them against the DUT.
  task automatic step(input string tag, input logic [3:0] g, input logic c,
                      input logic [3:0] a, input logic [3:0] e, input logic [3:0] r);
    exp_t x;
    sb_q.push_back('{tag, g, c, a, e, r});
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      x = sb_q.pop_front();
      chk({x.tag, ".gnt"}, 64'(gnt_o),   64'(x.gnt));
      chk({x.tag, ".cyc"}, 64'(s_cyc_o), 64'(x.cyc));
      chk({x.tag, ".ack"}, 64'(m_ack_o), 64'(x.ack));
      chk({x.tag, ".err"}, 64'(m_err_o), 64'(x.err));
      chk({x.tag, ".rty"}, 64'(m_rty_o), 64'(x.rty));
    end
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  task automatic req(input logic [3:0] c);
    m_cyc_i = c;
    m_stb_i = c;
  endtask

  initial begin
    rst_i   = 1'b1;
    m_cyc_i = '0; m_stb_i = '0; m_we_i = 4'b1010;
    m_cti_i = '0; m_bte_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = 32'hDEAD_BEEF;
    for (int k = 0; k < N; k++) begin
      m_adr_i[k*AW +: AW] = 32'hA000_0000 + 32'(k) * 32'h100;
      m_dat_i[k*DW +: DW] = 32'h1111_0000 + 32'(k);
      m_sel_i[k*SW +: SW] = 4'hF;
    end

    nxt();
    step("reset", 4'b0001, 1'b0, 4'h0, 4'h0, 4'h0);
    nxt();
    rst_i = 1'b0;

    // Single master, ack on the third request cycle
    req(4'b0001);
    step("t1_req", 4'b0001, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    step("t1_own", 4'b0001, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("t1_adr", 64'(s_adr_o), 64'h0000_0000_A000_0000); nxt();
    s_ack_i = 1'b1;
    step("t1_ack", 4'b0001, 1'b1, 4'b0001, 4'h0, 4'h0); nxt();
    s_ack_i = 1'b0;
    step("t1_post", 4'b0001, 1'b1, 4'h0, 4'h0, 4'h0); nxt();
    req(4'b0000);
    step("t1_rel", 4'b0001, 1'b0, 4'h0, 4'h0, 4'h0); nxt();

    // Masters 1 and 3 together; master 1 first, one IDLE cycle, then master 3
    req(4'b1010);
    step("t2_arb", 4'b0001, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    s_ack_i = 1'b1;
    step("t2_m1", 4'b0010, 1'b1, 4'b0010, 4'h0, 4'h0);
    chk("t2_adr1", 64'(s_adr_o), 64'h0000_0000_A000_0100);
    chk("t2_we1", 64'(s_we_o), 64'd1); nxt();
    s_ack_i = 1'b0; req(4'b1000);
    step("t2_rel1", 4'b0010, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    step("t2_idle", 4'b0010, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    s_err_i = 1'b1;
    step("t2_m3_err", 4'b1000, 1'b1, 4'h0, 4'b1000, 4'h0);
    chk("t2_adr3", 64'(s_adr_o), 64'h0000_0000_A000_0300); nxt();
    s_err_i = 1'b0; s_rty_i = 1'b1;
    step("t2_m3_rty", 4'b1000, 1'b1, 4'h0, 4'h0, 4'b1000); nxt();
    s_rty_i = 1'b0; req(4'b0000);
    step("t2_rel3", 4'b1000, 1'b0, 4'h0, 4'h0, 4'h0); nxt();

    // Masters 0 and 2 keep requesting; grants alternate
    req(4'b0101);
    step("t3_arb", 4'b1000, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    s_ack_i = 1'b1;
    step("t3_m0", 4'b0001, 1'b1, 4'b0001, 4'h0, 4'h0); nxt();
    s_ack_i = 1'b0; req(4'b0100);
    step("t3_rel0", 4'b0001, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    req(4'b0101);
    step("t3_idle0", 4'b0001, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    s_ack_i = 1'b1;
    step("t3_m2", 4'b0100, 1'b1, 4'b0100, 4'h0, 4'h0); nxt();
    s_ack_i = 1'b0; req(4'b0001);
    step("t3_rel2", 4'b0100, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    req(4'b0101);
    step("t3_idle2", 4'b0100, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    step("t3_m0b", 4'b0001, 1'b1, 4'h0, 4'h0, 4'h0); nxt();
    req(4'b0000);
    step("t3_end", 4'b0001, 1'b0, 4'h0, 4'h0, 4'h0); nxt();

    // Master 3 incrementing burst while master 1 waits
    req(4'b1000);
    step("t4_arb", 4'b0001, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    for (int b = 0; b < 3; b++) begin
      req(4'b1010);
      m_adr_i[3*AW +: AW] = 32'hB000_0000 + 32'(b) * 32'd4;
      m_sel_i[3*SW +: SW] = (b == 0) ? 4'hF : ((b == 1) ? 4'h3 : 4'hC);
      m_cti_i[3*3 +: 3]   = (b < 2) ? CTI_INCR : CTI_EOB;
      m_bte_i[3*2 +: 2]   = BTE_LINEAR;
      s_ack_i = 1'b1;
      step("t4_beat", 4'b1000, 1'b1, 4'b1000, 4'h0, 4'h0);
      chk("t4_adr", 64'(s_adr_o), 64'(32'hB000_0000 + 32'(b) * 32'd4));
      chk("t4_sel", 64'(s_sel_o), (b == 0) ? 64'hF : ((b == 1) ? 64'h3 : 64'hC));
      chk("t4_cti", 64'(s_cti_o), (b < 2) ? 64'(CTI_INCR) : 64'(CTI_EOB));
      nxt();
    end
    s_ack_i = 1'b0; req(4'b0010);
    step("t4_rel3", 4'b1000, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    step("t4_idle", 4'b1000, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    step("t4_m1", 4'b0010, 1'b1, 4'h0, 4'h0, 4'h0);
    chk("t4_dat", 64'(s_dat_o), 64'h0000_0000_1111_0001);
    chk("t4_rdat", 64'(m_dat_o), 64'h0000_0000_DEAD_BEEF); nxt();
    req(4'b0000);
    step("t4_end", 4'b0010, 1'b0, 4'h0, 4'h0, 4'h0); nxt();

    // Watchdog: 8 unterminated strobes, abort in the 9th bus cycle
    req(4'b0100);
    step("t5_arb", 4'b0010, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    for (int i = 0; i < 8; i++) begin
      step("t5_wait", 4'b0100, 1'b1, 4'h0, 4'h0, 4'h0);
      chk("t5_stb", 64'(s_stb_o), 64'd1); nxt();
    end
    s_ack_i = 1'b1;
    step("t5_abort", 4'b0100, 1'b0, 4'h0, 4'b0100, 4'h0);
    chk("t5_abort_stb", 64'(s_stb_o), 64'd0); nxt();
    s_ack_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step("t5_wait2", 4'b0100, 1'b1, 4'h0, 4'h0, 4'h0); nxt();
    end
    s_ack_i = 1'b1;
    step("t5_ack7", 4'b0100, 1'b1, 4'b0100, 4'h0, 4'h0); nxt();
    s_ack_i = 1'b0;
    step("t5_noabort", 4'b0100, 1'b1, 4'h0, 4'h0, 4'h0); nxt();
    req(4'b0000);
    step("t5_end", 4'b0100, 1'b0, 4'h0, 4'h0, 4'h0); nxt();

    // Async reset in the middle of master 1's cycle
    req(4'b0010);
    step("t6_arb", 4'b0100, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    s_ack_i = 1'b1;
    step("t6_m1", 4'b0010, 1'b1, 4'b0010, 4'h0, 4'h0);
    #1 rst_i = 1'b1;
    step("t6_rst", 4'b0001, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    rst_i = 1'b0; s_ack_i = 1'b0;
    step("t6_rearb", 4'b0001, 1'b0, 4'h0, 4'h0, 4'h0); nxt();
    step("t6_m1b", 4'b0010, 1'b1, 4'h0, 4'h0, 4'h0); nxt();
    req(4'b0000);
    step("t6_end", 4'b0010, 1'b0, 4'h0, 4'h0, 4'h0); nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_bus_master_arbiter.md
Name: wb_bus_master_arbiter

Overview:
Shares one Wishbone B3 slave-side bus between N masters.
- Owns a registered one-hot grant; next grant comes from the combinational round-robin arbiter.
- Holds bus ownership for the full cycle of the granted master, and muxes that master's signals to the bus.
- Routes termination back to the granted master only, and aborts stalled cycles with a watchdog.
- Sits between the master ports of the compute tiles and the address decoder/slave mux of the shared bus.

Parameters:
N, 4, number of masters (>=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; SEL_WIDTH = DATA_WIDTH/8
TIMEOUT, 256, cycles of unterminated strobe before abort; 0 disables watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
m_cyc_i  in  N  per-master cycle
m_stb_i  in  N  per-master strobe
m_we_i  in  N  per-master write enable
m_adr_i  in  N*ADDR_WIDTH  flattened addresses, master k at [k*ADDR_WIDTH +: ADDR_WIDTH]
m_dat_i  in  N*DATA_WIDTH  flattened write data
m_sel_i  in  N*SEL_WIDTH  flattened byte selects
m_cti_i  in  N*3  flattened cycle type
m_bte_i  in  N*2  flattened burst type
m_ack_o  out  N  ack, granted master only
m_err_o  out  N  err, granted master only
m_rty_o  out  N  retry, granted master only
m_dat_o  out  DATA_WIDTH  read data, broadcast (s_dat_i)
s_cyc_o, s_stb_o, s_we_o  out  1 each  bus control
s_adr_o  out  ADDR_WIDTH  bus address
s_dat_o  out  DATA_WIDTH  bus write data
s_sel_o  out  SEL_WIDTH  bus byte select
s_cti_o  out  3  bus cycle type
s_bte_o  out  2  bus burst type
s_ack_i, s_err_i, s_rty_i  in  1 each  bus termination
s_dat_i  in  DATA_WIDTH  bus read data
gnt_o  out  N  registered one-hot grant (debug/visibility)

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, gnt=1 (master 0), watchdog=0.
  - s_cyc_o=s_stb_o=0.
  - All m_ack_o/m_err_o/m_rty_o=0.
- gnt is always one-hot. Next grant uses round-robin with req=m_cyc_i and the current gnt: the master immediately after the current holder in round-robin order wins. With no request, gnt is held.
- FSM:
  - IDLE:
    - s_cyc_o=0.
    - If |m_cyc_i: gnt<=nxt_gnt; go OWN. Arbitration latency is 1 cycle; first bus cycle is the cycle after the request is seen.
    - Else stay; gnt unchanged.
  - OWN:
    - s_* = granted master's inputs, s_cyc_o = m_cyc_i[g].
    - m_ack_o[g]=s_ack_i, same for err/rty; all other master terminations are 0.
    - Stay while m_cyc_i[g]=1, including across bursts and idle strobes (RMW lock).
    - When m_cyc_i[g] drops: go IDLE.
    - Handover to another master therefore takes 2 cycles: the release cycle plus the IDLE arbitration cycle.
  - ABORT (one cycle):
    - s_cyc_o=s_stb_o=0; m_err_o[g]=1; terminations from s_* are ignored.
    - Next state is OWN if m_cyc_i[g] is still 1, else IDLE.
- Watchdog (TIMEOUT>0):
  - Counter width $clog2(TIMEOUT+1).
  - Cleared on any state change, and in any cycle with s_ack_i|s_err_i|s_rty_i or s_stb_o=0.
  - Increments in OWN while s_stb_o=1 with no termination.
  - Reaching TIMEOUT-1 with no termination in that cycle moves the FSM to ABORT next.
  - A termination arriving in the same cycle as the threshold wins; no abort.
- If the granted master drops cyc mid-burst, the cycle ends immediately with no abort. s_cyc_o follows combinationally, so the slave sees cyc low in the same cycle.
- Non-granted masters see no termination and simply wait. Their requests remain visible to the next arbitration.
- Reset asserted mid-cycle: the bus releases immediately (async) and grant returns to master 0.
- No combinational path from nxt_gnt to gnt.
- Only the s_* mux and the termination routing are combinational in gnt.

Decomposition:
- Shared package holds:
  - the state typedef (enum logic [1:0] {IDLE, OWN, ABORT});
  - Wishbone CTI/BTE constants;
  - a one-hot-to-index function.
- The existing combinational round-robin arbiter wb_interconnect_arb_rr is instantiated as the single sub-module, with N passed through, req=m_cyc_i and gnt=registered gnt.
- Muxing and FSM are inline.

Test Plan:
- Reset, then m_cyc_i=0001 for 4 cycles with s_ack_i on cycle 3.
  -> gnt_o=0001; s_cyc_o rises 1 cycle after request; m_ack_o=0001 only on the ack cycle.
- m_cyc_i=1010 simultaneously from IDLE with gnt=0001.
  -> master 1 granted first (gnt_o=0010); after it releases, IDLE 1 cycle, then gnt_o=1000.
- Masters 0 and 2 both hold cyc continuously, each releasing after one ack.
  -> grants alternate 0001, 0100, 0001.
  -> Each master's wait is bounded at 2 turns.
- Granted master 3-beat incrementing burst (cti=010, then 111) while master 1 requests.
  -> no ownership change until master 3 drops cyc; s_adr_o/s_sel_o track master 3 every cycle.
- TIMEOUT=8, granted master strobes, slave never terminates.
  -> in the 9th cycle the FSM is in ABORT, s_cyc_o=0, m_err_o[g]=1 for exactly one cycle.
  -> s_ack_i at count 7 instead gives ack with no err.
- Async rst_i pulse mid-burst.
  -> s_cyc_o=0, gnt_o=0001, all terminations 0 within the same cycle; normal arbitration resumes after deassert.
